seq_shifter: RTL and testbench

Parametrised multi-cycle shift unit for the ALU, generalising the 32-bit combinational logical left shift. It supports four shift modes and any power-of-two width, and shifts by at most STEP bits per clock, so area scales with STEP rather than WIDTH. A start/busy/done handshake lets the ALU control sequencer issue an operation and collect a registered result.

---
 rtl/seq_shifter.sv | 108 ++++++++++
 tb/tb_seq_shifter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle shift unit: SLL/SRL/SRA/ROL by up to STEP bit positions per clock,
// with a start/busy/done handshake and a registered result.
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int SHW = $clog2(WIDTH);
  // STEP <= WIDTH = 2**SHW, so one extra bit always holds it.
  localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROL} op_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       opr_q, opr_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [SHW-1:0]   k;
  logic [WIDTH-1:0] shifted;
  logic             accept;

  // Only the low SHW bits of the amount are meaningful.
  logic unused_b;
  assign unused_b = ^b[WIDTH-1:SHW];

  function automatic logic [WIDTH-1:0] shift_by(input logic [1:0] mode,
                                                input logic [WIDTH-1:0] x,
                                                input logic [SHW-1:0] amt);
    logic [WIDTH-1:0] r;
    logic [SHW:0]     ramt;
    ramt = (SHW+1)'(WIDTH) - {1'b0, amt};
    case (op_e'(mode))
      OP_SLL:  r = x << amt;
      OP_SRL:  r = x >> amt;
      OP_SRA:  r = $signed(x) >>> amt;
      default: r = (x << amt) | (x >> ramt);  // amt=0 gives x >> WIDTH = 0
    endcase
    return r;
  endfunction

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    opr_d    = opr_q;
    result_d = result_q;

    k       = ({1'b0, cnt_q} < STEP_W) ? cnt_q : STEP_W[SHW-1:0];
    shifted = shift_by(opr_q, acc_q, k);
    accept  = start && (state_q != SHIFT);

    case (state_q)
      SHIFT: begin
        acc_d = shifted;
        cnt_d = cnt_q - k;
        if ({1'b0, cnt_q} <= STEP_W) begin
          state_d  = DONE;
          result_d = shifted;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = SHIFT;
      acc_d   = a;
      cnt_d   = b[SHW-1:0];
      opr_d   = op;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous and clears every register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      opr_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      opr_q    <= opr_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter (WIDTH=32, STEP=4): directed and random
// operations through a result/latency scoreboard, handshake and reset cases.
module tb_seq_shifter;
  localparam int W  = 32;
  localparam int ST = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  seq_shifter #(.WIDTH(W), .STEP(ST)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bit-at-a-time reference shifter.
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] amt);
    logic [W-1:0] r;
    int sh;
    r  = x;
    sh = int'(amt[4:0]);
    for (int i = 0; i < sh; i++) begin
      case (o)
        2'd0:    r = {r[W-2:0], 1'b0};
        2'd1:    r = {1'b0, r[W-1:1]};
        2'd2:    r = {r[W-1], r[W-1:1]};
        default: r = {r[W-2:0], r[W-1]};
      endcase
    end
    return r;
  endfunction

  // Rising edges from the accepting edge up to the one after which done is seen.
  function automatic int latency(input logic [W-1:0] amt);
    int sh;
    sh = int'(amt[4:0]);
    return ((sh == 0) ? 1 : (sh + ST - 1) / ST) + 1;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] amt,
                       input logic [W-1:0] exp_res);
    exp_t e;
    op = o; a = x; b = amt; start = 1'b1;
    e.res = exp_res;
    e.lat = latency(amt);
    sb.push_back(e);
  endtask

  // Call with inputs already driven before the accepting edge.
  task automatic collect(input string tag, input bit drop_start, input int poke);
    int   edges;
    exp_t e;
    edges = 0;
    forever begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) check({tag, " busy"}, {31'b0, busy}, 32'd1);
      if (done || edges >= 64) break;
      if (edges == poke) begin
        start = 1'b1;
        a     = ~a;
      end else if (drop_start) begin
        start = 1'b0;
      end
    end
    if (!done) check({tag, " timeout"}, {31'b0, done}, 32'd1);
    e = sb.pop_front();
    check({tag, " result"}, result, e.res);
    check({tag, " latency"}, 32'(edges), 32'(e.lat));
    check({tag, " not busy at done"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic tail(input string tag);
    @(negedge clk);
    check({tag, " done falls"}, {31'b0, done}, 32'd0);
    check({tag, " idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] amt, input logic [W-1:0] exp_res);
    @(negedge clk);
    issue(o, x, amt, exp_res);
    collect(tag, 1'b1, 0);
    tail(tag);
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    bit           seen_done;

    rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", result, 32'h0);
    rst = 1'b0;

    run_op("sll 1<<1",   2'd0, 32'h0000_0001, 32'd1,  32'h0000_0002);
    run_op("sll 2<<2",   2'd0, 32'h0000_0002, 32'd2,  32'h0000_0008);
    run_op("sll 8df<<5", 2'd0, 32'h0000_08DF, 32'd5,  32'h0001_1BE0);
    run_op("sll 1<<31",  2'd0, 32'h0000_0001, 32'h1F, 32'h8000_0000);
    run_op("sra",        2'd2, 32'h8000_0000, 32'd4,  32'hF800_0000);
    run_op("srl",        2'd1, 32'h8000_0000, 32'd4,  32'h0800_0000);
    run_op("rol",        2'd3, 32'h8000_0001, 32'd4,  32'h0000_0018);
    run_op("zero shift", 2'd0, 32'hDEAD_BEEF, 32'd0,  32'hDEAD_BEEF);
    run_op("b=21h",      2'd0, 32'h0000_0001, 32'h21, 32'h0000_0002);
    run_op("sra ones",   2'd2, 32'hFFFF_FFFF, 32'h1F, 32'hFFFF_FFFF);

    // start pulsed while busy with a different operand must be ignored
    @(negedge clk);
    issue(2'd0, 32'h0000_0001, 32'd8, 32'h0000_0100);
    collect("ignore busy start", 1'b1, 1);
    tail("ignore busy start");

    // start held through DONE: second op accepted with no idle cycle
    @(negedge clk);
    issue(2'd1, 32'hF000_0000, 32'd6, 32'h03C0_0000);
    collect("chain first", 1'b0, 0);
    issue(2'd3, 32'h1234_5678, 32'd8, 32'h3456_7812);
    collect("chain second", 1'b1, 0);
    tail("chain second");

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      run_op($sformatf("random %0d", i), ro, ra, rb, model(ro, ra, rb));
    end

    // asynchronous reset in the middle of a long shift
    run_op("pre-reset", 2'd3, 32'h0000_00F1, 32'd3, 32'h0000_0788);
    @(negedge clk);
    issue(2'd0, 32'h0000_0001, 32'h1F, 32'h8000_0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst result", result, 32'h0);
    void'(sb.pop_front());
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("no done after rst", {31'b0, seen_done}, 32'd0);
    check("result held 0", result, 32'h0);
    run_op("post-reset", 2'd2, 32'h8000_00F0, 32'd9, 32'hFFC0_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
